// File: rtl/led_scan_driver_pkg.sv
// Shared 7-segment glyph constants for the display blocks.
// Glyphs are active-low {g,f,e,d,c,b,a}; the dp bit is added by the consumer.
package led_scan_driver_pkg;
   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_E    = 7'h06;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [3:0] AN_OFF   = 4'hF;
endpackage

// File: rtl/led_scan_driver_seg7_encode.sv
// Nibble to active-low 7-segment glyph; non-BCD nibbles render as 'E'.
module seg7_encode
   import led_scan_driver_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);
   always_comb begin
      o_seg = SEG_E;
      case (i_nib)
         4'd0: o_seg = SEG_0;
         4'd1: o_seg = SEG_1;
         4'd2: o_seg = SEG_2;
         4'd3: o_seg = SEG_3;
         4'd4: o_seg = SEG_4;
         4'd5: o_seg = SEG_5;
         4'd6: o_seg = SEG_6;
         4'd7: o_seg = SEG_7;
         4'd8: o_seg = SEG_8;
         4'd9: o_seg = SEG_9;
         default: o_seg = SEG_E;
      endcase
   end
endmodule

// File: rtl/led_scan_driver.sv
// 4-digit common-anode scan driver with leading-zero blanking, range dp,
// overflow dashes and a dark guard interval at the start of each digit slot.
module led_scan_driver
   import led_scan_driver_pkg::*;
#(
   parameter int SCAN_DIV  = 100_000,
   parameter int GHOST_CYC = 1000,
   parameter bit BLANK_LZ  = 1'b1
)(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] num,
   input  logic        load,
   input  logic        ovf,
   input  logic        range,
   output logic [3:0]  anodes,
   output logic [7:0]  cathodes
);
   localparam int             CW    = $clog2(SCAN_DIV);
   localparam logic [CW-1:0]  LAST  = CW'(SCAN_DIV - 1);
   localparam logic [CW-1:0]  GHOST = CW'(GHOST_CYC);

   logic [CW-1:0] r_cnt;
   logic [1:0]    r_idx;
   logic [15:0]   r_num;
   logic          r_ovf;
   logic          r_rng;

   logic [3:0]    w_nib;
   logic [6:0]    w_glyph;
   logic [3:0]    w_hi_zero;
   logic          w_blank;
   logic          w_dp_n;
   logic [7:0]    w_seg;
   logic          w_dark;

   assign w_nib = r_num[{r_idx, 2'b00} +: 4];

   seg7_encode u_enc (
      .i_nib (w_nib),
      .o_seg (w_glyph)
   );

   // w_hi_zero[k]: nibbles k..3 are all zero
   assign w_hi_zero[3] = (r_num[15:12] == 4'd0);
   assign w_hi_zero[2] = w_hi_zero[3] & (r_num[11:8] == 4'd0);
   assign w_hi_zero[1] = w_hi_zero[2] & (r_num[7:4]  == 4'd0);
   assign w_hi_zero[0] = w_hi_zero[1] & (r_num[3:0]  == 4'd0);

   assign w_blank = BLANK_LZ && (r_idx != 2'd0) && w_hi_zero[r_idx];
   assign w_dp_n  = !((r_idx == 2'd3) && r_rng);
   assign w_dark  = (r_cnt < GHOST);

   always_comb begin
      w_seg = {1'b1, SEG_OFF};
      if (r_ovf)        w_seg = {1'b1, SEG_DASH};
      else if (w_blank) w_seg = {1'b1, SEG_OFF};
      else              w_seg = {w_dp_n, w_glyph};
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt    <= '0;
         r_idx    <= 2'd0;
         r_num    <= 16'h0000;
         r_ovf    <= 1'b0;
         r_rng    <= 1'b0;
         anodes   <= AN_OFF;
         cathodes <= {1'b1, SEG_OFF};
      end else begin
         if (r_cnt == LAST) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
         if (load) begin
            r_num <= num;
            r_ovf <= ovf;
            r_rng <= range;
         end
         anodes   <= w_dark ? AN_OFF : ~(4'b0001 << r_idx);
         cathodes <= w_dark ? {1'b1, SEG_OFF} : w_seg;
      end
   end
endmodule

// File: tb/tb_led_scan_driver.sv
// Scoreboard bench: driver pushes expected outputs per clock from a
// slot/digit arithmetic model; monitor pops and compares after each edge.
module tb_led_scan_driver;
   localparam int SD = 4;
   localparam int GH = 1;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [15:0] num;
   logic        load, ovf, range;
   logic [3:0]  anodes;
   logic [7:0]  cathodes;

   typedef struct {
      logic [3:0] an;
      logic [7:0] ca;
   } exp_t;
   exp_t q[$];

   int checks = 0;
   int errors = 0;

   // model state: cycles since reset, last captured load
   int          m_c   = 0;
   logic [15:0] m_num = 16'h0;
   logic        m_ovf = 1'b0;
   logic        m_rng = 1'b0;

   led_scan_driver #(.SCAN_DIV(SD), .GHOST_CYC(GH), .BLANK_LZ(1'b1)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .num      (num),
      .load     (load),
      .ovf      (ovf),
      .range    (range),
      .anodes   (anodes),
      .cathodes (cathodes)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] glyph(input int d);
      case (d)
         0: return 8'hC0;  1: return 8'hF9;  2: return 8'hA4;  3: return 8'hB0;
         4: return 8'h99;  5: return 8'h92;  6: return 8'h82;  7: return 8'hF8;
         8: return 8'h80;  9: return 8'h90;  default: return 8'h86;
      endcase
   endfunction

   function automatic logic [7:0] exp_cath(input int k, input logic [15:0] v,
                                           input logic o, input logic r);
      int d;
      logic [7:0] g;
      if (o) return 8'hBF;
      if (k >= 1 && (int'(v) >> (4 * k)) == 0) return 8'hFF;
      d = (int'(v) >> (4 * k)) % 16;
      g = glyph(d);
      if (k == 3 && r) g[7] = 1'b0;
      return g;
   endfunction

   task automatic step(input logic rn, input logic ld, input logic [15:0] n,
                       input logic o, input logic r);
      exp_t e;
      int   pos, idx;
      reset_n = rn; load = ld; num = n; ovf = o; range = r;
      if (!rn) begin
         e.an = 4'hF; e.ca = 8'hFF;
         m_c = 0; m_num = 16'h0; m_ovf = 1'b0; m_rng = 1'b0;
      end else begin
         pos = m_c % SD;
         idx = (m_c / SD) % 4;
         if (pos < GH) begin
            e.an = 4'hF; e.ca = 8'hFF;
         end else begin
            e.an = 4'hF;
            e.an[idx] = 1'b0;
            e.ca = exp_cath(idx, m_num, m_ovf, m_rng);
         end
         m_c++;
         if (ld) begin m_num = n; m_ovf = o; m_rng = r; end
      end
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'($urandom), 1'b0, 1'b0);
   endtask

   function automatic logic [15:0] rand_num();
      logic [15:0] v;
      for (int k = 0; k < 4; k++)
         v[4*k +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                   : 4'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
         0: v[15:4]  = 12'h0;
         1: v[15:8]  = 8'h0;
         2: v[15:12] = 4'h0;
         default: ;
      endcase
      return v;
   endfunction

   // monitor
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty t=%0t anodes=%b cathodes=%h", $time, anodes, cathodes);
         end else begin
            e = q.pop_front();
            if (anodes !== e.an || cathodes !== e.ca) begin
               errors++;
               $display("FAIL scan t=%0t anodes=%b cathodes=%h expected anodes=%b cathodes=%h",
                        $time, anodes, cathodes, e.an, e.ca);
            end
         end
         checks++;
         if ($countones(~anodes) > 1) begin
            errors++;
            $display("FAIL one_anode t=%0t anodes=%b expected at most one low", $time, anodes);
         end
      end
   end

   // driver
   initial begin
      logic rn, ld;
      reset_n = 1'b0; load = 1'b0; num = 16'h0; ovf = 1'b0; range = 1'b0;
      repeat (3) step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      idle(8);
      step(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0);  idle(20);
      step(1'b1, 1'b1, 16'h0070, 1'b0, 1'b0);  idle(17);
      step(1'b1, 1'b1, 16'h0070, 1'b0, 1'b1);  idle(17);
      step(1'b1, 1'b1, 16'h1070, 1'b0, 1'b1);  idle(17);
      step(1'b1, 1'b1, 16'h9999, 1'b1, 1'b1);  idle(17);
      step(1'b1, 1'b1, 16'h00A5, 1'b0, 1'b0);  idle(18);
      step(1'b1, 1'b1, 16'h0000, 1'b0, 1'b1);  idle(17);
      idle(2);
      step(1'b1, 1'b1, 16'h8888, 1'b0, 1'b1);  idle(3);
      step(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);     idle(10);
      for (int i = 0; i < 600; i++) begin
         rn = ($urandom_range(0, 99) != 0);
         ld = ($urandom_range(0, 7) == 0);
         step(rn, ld, rand_num(), ($urandom_range(0, 7) == 0), 1'($urandom));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
